mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 63 ++++++
 rtl/mem_port_fsm.sv | 60 ++++++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared width, funct3 encodings, port FSM states and lane helpers for mem_responder.
// Alignment checking is enabled by defining MEM_MISALIGN_CHECK_EN.
package mem_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } port_state_t;

    function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                    input logic [1:0] lo,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_W:    load_extend = word;
            F3_BU:   load_extend = {24'd0, b};
            F3_HU:   load_extend = {16'd0, h};
            default: load_extend = '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B:    store_mask = 32'h0000_00FF << {lo, 3'b000};
            F3_H:    store_mask = lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            F3_W:    store_mask = 32'hFFFF_FFFF;
            default: store_mask = '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] f3, input logic [1:0] lo,
                                                   input logic [XLEN-1:0] data);
        case (f3)
            F3_B:    store_data = {4{data[7:0]}};
            F3_H:    store_data = {2{data[15:0]}};
            default: store_data = data;
        endcase
        if (lo == 2'b11 && f3 == 3'b111) store_data = '0;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: misaligned = lo[0];
            F3_W:        misaligned = (lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// One request port: IDLE -> WAIT -> ACK sequencer that latches the request payload on acceptance.
module mem_port_fsm
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int PW          = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic [PW-1:0] payload_i,
    output logic [PW-1:0] payload_o,
    output logic          go_o,
    output logic          ack_o
);

    localparam logic [3:0] LAST_COUNT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    port_state_t   state_q;
    logic [3:0]    count_q;
    logic [PW-1:0] payload_q;
    logic          ack_q;

    // With no wait states the access happens on the accepting edge, so the live inputs are used.
    assign payload_o = (state_q == ST_IDLE) ? payload_i : payload_q;
    assign go_o      = ((state_q == ST_IDLE) && req_i && (WAIT_CYCLES == 0)) ||
                       ((state_q == ST_WAIT) && (count_q == LAST_COUNT));
    assign ack_o     = ack_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            payload_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= go_o;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        payload_q <= payload_i;
                        count_q   <= '0;
                        state_q   <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count_q == LAST_COUNT) begin
                        count_q <= '0;
                        state_q <= ST_ACK;
                    end else begin
                        count_q <= count_q + 4'd1;
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Dual-port (fetch + data) word memory with fixed-latency handshakes and RV32I load/store lanes.
// Define MEM_MISALIGN_CHECK_EN to reject misaligned accesses through or_data_err.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_inst_req,
    input  logic [XLEN-1:0] i_inst_addr,
    output logic            or_inst_ack,
    output logic [XLEN-1:0] or_inst_data,
    input  logic            i_data_req,
    input  logic [XLEN-1:0] i_data_addr,
    input  logic [XLEN-1:0] i_data,
    input  logic [2:0]      i_funct3,
    input  logic            i_read_write,
    output logic            or_data_ack,
    output logic [XLEN-1:0] or_data
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    output logic            or_data_err
`endif
);

    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int DPW = 2 * XLEN + 4;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] inst_data_q, data_q;
    logic            err_q;

    logic [XLEN-1:0] inst_addr, d_addr, d_wdata, wr_mask, wr_bits;
    logic [DPW-1:0]  data_payload;
    logic [2:0]      d_f3;
    logic            d_rw, inst_go, data_go, inst_mis, data_mis, do_store, do_load;
    logic [AW-1:0]   inst_idx, data_idx;
    logic            unused_addr_bits;

    mem_port_fsm #(.WAIT_CYCLES(WAIT_CYCLES), .PW(XLEN)) u_inst_port (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .req_i     (i_inst_req),
        .payload_i (i_inst_addr),
        .payload_o (inst_addr),
        .go_o      (inst_go),
        .ack_o     (or_inst_ack)
    );

    mem_port_fsm #(.WAIT_CYCLES(WAIT_CYCLES), .PW(DPW)) u_data_port (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .req_i     (i_data_req),
        .payload_i ({i_read_write, i_funct3, i_data, i_data_addr}),
        .payload_o (data_payload),
        .go_o      (data_go),
        .ack_o     (or_data_ack)
    );

    assign {d_rw, d_f3, d_wdata, d_addr} = data_payload;
    assign inst_idx = inst_addr[AW+1:2];
    assign data_idx = d_addr[AW+1:2];
    assign unused_addr_bits = ^{inst_addr[XLEN-1:AW+2], inst_addr[1:0], d_addr[XLEN-1:AW+2]};

`ifdef MEM_MISALIGN_CHECK_EN
    assign inst_mis = (inst_addr[1:0] != 2'b00);
    assign data_mis = misaligned(d_f3, d_addr[1:0]);
`else
    assign inst_mis = 1'b0;
    assign data_mis = 1'b0;
`endif

    assign do_store = d_rw && (d_f3 == F3_B || d_f3 == F3_H || d_f3 == F3_W) && !data_mis;
    assign do_load  = !d_rw && (d_f3 == F3_B || d_f3 == F3_H || d_f3 == F3_W ||
                                d_f3 == F3_BU || d_f3 == F3_HU) && !data_mis;
    assign wr_mask  = store_mask(d_f3, d_addr[1:0]);
    assign wr_bits  = store_data(d_f3, d_addr[1:0], d_wdata);

    // Storage is never reset; a reset in the access cycle suppresses the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && data_go && do_store)
            mem_q[data_idx] <= (mem_q[data_idx] & ~wr_mask) | (wr_bits & wr_mask);
    end

    // Reads see pre-edge contents, so a same-edge fetch returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            inst_data_q <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            inst_data_q <= (inst_go && !inst_mis) ? mem_q[inst_idx] : '0;
            data_q      <= (data_go && do_load) ? load_extend(d_f3, d_addr[1:0], mem_q[data_idx]) : '0;
            err_q       <= (inst_go && inst_mis) || (data_go && data_mis);
        end
    end

    assign or_inst_data = inst_data_q;
    assign or_data      = data_q;
`ifdef MEM_MISALIGN_CHECK_EN
    assign or_data_err  = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a byte-level memory model.
// Covers MEM_MISALIGN_CHECK_EN when the macro is defined for the build.
module tb_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instReq = 1'b0, dataReq = 1'b0, readWrite = 1'b0;
    logic [31:0] instAddr = '0, dataAddr = '0, dataWdata = '0;
    logic [2:0]  funct3 = '0;
    logic        instAck, dataAck;
    logic [31:0] instData, dataRdata;

    logic        zReq = 1'b0, zRw = 1'b0;
    logic [31:0] zAddr = '0, zWdata = '0;
    logic [2:0]  zF3 = '0;
    logic        zAck, zInstAck;
    logic [31:0] zData, zInstData;

`ifdef MEM_MISALIGN_CHECK_EN
    logic        dataErr, zErr;
`endif

    int tests = 0;
    int failures = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_inst_req(instReq), .i_inst_addr(instAddr),
        .or_inst_ack(instAck), .or_inst_data(instData),
        .i_data_req(dataReq), .i_data_addr(dataAddr), .i_data(dataWdata),
        .i_funct3(funct3), .i_read_write(readWrite),
        .or_data_ack(dataAck), .or_data(dataRdata)
`ifdef MEM_MISALIGN_CHECK_EN
        , .or_data_err(dataErr)
`endif
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dutZero (
        .i_clk(clk), .i_rst(rst),
        .i_inst_req(1'b0), .i_inst_addr(32'h0),
        .or_inst_ack(zInstAck), .or_inst_data(zInstData),
        .i_data_req(zReq), .i_data_addr(zAddr), .i_data(zWdata),
        .i_funct3(zF3), .i_read_write(zRw),
        .or_data_ack(zAck), .or_data(zData)
`ifdef MEM_MISALIGN_CHECK_EN
        , .or_data_err(zErr)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int modelIdx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    function automatic bit modelMis(input bit fetch, input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_MISALIGN_CHECK_EN
        if (fetch) return (addr % 4) != 0;
        if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) != 0;
        if (f3 == 3'd2) return (addr % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] w, b, h;
        w = model[modelIdx(addr)];
        b = (w >> (8 * (addr % 4))) % 256;
        h = (w >> (16 * ((addr % 4) / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        int size, start, idx;
        logic [31:0] w, byteVal;
        size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        start = int'(addr % 4) - (int'(addr % 4) % size);
        idx   = modelIdx(addr);
        w     = model[idx];
        for (int i = 0; i < size; i++) begin
            byteVal = (data >> (8 * i)) & 32'hFF;
            w = (w & ~(32'hFF << (8 * (start + i)))) | (byteVal << (8 * (start + i)));
        end
        model[idx] = w;
    endtask

    // Drives one fetch and/or data request, holds req until ack, and checks latency and results.
    task automatic applyStimulus(input bit doI, input logic [31:0] iAddr, input bit doD, input bit rw,
                                 input logic [31:0] dAddr, input logic [31:0] wdata, input logic [2:0] f3);
        logic [31:0] expI, expD;
        bit misI, misD, gotI, gotD, leak;
        misI = doI && modelMis(1'b1, 3'd0, iAddr);
        misD = doD && modelMis(1'b0, f3, dAddr);
        expI = (doI && !misI) ? model[modelIdx(iAddr)] : 32'h0;
        expD = (doD && !rw && !misD) ? modelLoad(f3, dAddr) : 32'h0;
        if (doD && rw && f3 <= 3'd2 && !misD) modelStore(f3, dAddr, wdata);
        @(negedge clk);
        instReq = doI; instAddr = iAddr;
        dataReq = doD; dataAddr = dAddr; dataWdata = wdata; funct3 = f3; readWrite = rw;
        @(posedge clk);
        #1;
        instAddr = $urandom; dataAddr = $urandom; dataWdata = $urandom;
        funct3 = 3'($urandom); readWrite = 1'($urandom);
        gotI = !doI; gotD = !doD; leak = 1'b0;
        for (int n = 1; n <= 20 && !(gotI && gotD); n++) begin
            @(negedge clk);
`ifdef MEM_MISALIGN_CHECK_EN
            if (instAck || dataAck)
                checkOutput("err", 32'(dataErr), 32'((instAck && misI) || (dataAck && misD)));
`endif
            if (instAck) begin
                checkOutput("instLatency", n, W + 1);
                checkOutput("instData", instData, expI);
                gotI = 1'b1; instReq = 1'b0;
            end else if (instData != 0) leak = 1'b1;
            if (dataAck) begin
                checkOutput("dataLatency", n, W + 1);
                checkOutput("dataRead", dataRdata, expD);
                gotD = 1'b1; dataReq = 1'b0;
            end else if (dataRdata != 0) leak = 1'b1;
        end
        checkOutput("instAckSeen", 32'(gotI), 32'd1);
        checkOutput("dataAckSeen", 32'(gotD), 32'd1);
        checkOutput("idleOutputsZero", 32'(leak), 32'd0);
        instReq = 1'b0; dataReq = 1'b0;
    endtask

    initial begin
        bit sawAck, consec, prev, badData;
        int ackCnt;
        logic [31:0] aliasv, dAddr, iAddr;
        int kind;

        repeat (3) @(negedge clk);
        checkOutput("rstInstAck", 32'(instAck), 32'd0);
        checkOutput("rstDataAck", 32'(dataAck), 32'd0);
        checkOutput("rstInstData", instData, 32'h0);
        checkOutput("rstDataRead", dataRdata, 32'h0);
        rst = 1'b0;

        applyStimulus(0, 0, 1, 1, 32'h200, 32'h0, 3'd2);
        applyStimulus(0, 0, 1, 1, 32'h300, 32'hA5A5_A5A5, 3'd2);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 1, 32'h400 + 32'(i * 4), $urandom, 3'd2);

        applyStimulus(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 3'd2);
        applyStimulus(0, 0, 1, 0, 32'h100, 32'h0, 3'd2);
        applyStimulus(0, 0, 1, 1, 32'h103, 32'h80, 3'd0);
        applyStimulus(0, 0, 1, 0, 32'h103, 32'h0, 3'd0);
        applyStimulus(0, 0, 1, 0, 32'h103, 32'h0, 3'd4);
        applyStimulus(0, 0, 1, 0, 32'h100, 32'h0, 3'd2);

        applyStimulus(1, 32'h200, 1, 1, 32'h200, 32'h1234_5678, 3'd2);
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 3'd0);

        // Reset lands while the store is still waiting: no ack, no write.
        @(negedge clk);
        dataReq = 1'b1; readWrite = 1'b1; dataAddr = 32'h300; dataWdata = 32'h55; funct3 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; dataReq = 1'b0;
        sawAck = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n == 2) rst = 1'b0;
            @(negedge clk);
            if (dataAck) sawAck = 1'b1;
        end
        checkOutput("rstAbandonNoAck", 32'(sawAck), 32'd0);
        applyStimulus(0, 0, 1, 0, 32'h300, 32'h0, 3'd2);

`ifdef MEM_MISALIGN_CHECK_EN
        applyStimulus(0, 0, 1, 0, 32'h102, 32'h0, 3'd2);
        applyStimulus(0, 0, 1, 1, 32'h101, 32'hFFFF, 3'd1);
        applyStimulus(0, 0, 1, 0, 32'h100, 32'h0, 3'd2);
        applyStimulus(1, 32'h402, 0, 0, 0, 0, 3'd0);
`endif

        for (int it = 0; it < 200; it++) begin
            kind   = int'($urandom_range(0, 3));
            aliasv = $urandom_range(0, 3) << 14;
            dAddr  = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3)) + aliasv;
            iAddr  = 32'h400 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            applyStimulus(kind != 1, iAddr, kind != 0, 1'($urandom), dAddr, $urandom, 3'($urandom));
        end

        // Zero-wait instance: req held continuously must ack on alternate cycles.
        @(negedge clk);
        zReq = 1'b1; zRw = 1'b1; zAddr = 32'h10; zWdata = 32'hCAFE_F00D; zF3 = 3'd2;
        @(negedge clk);
        checkOutput("z0StoreAck", 32'(zAck), 32'd1);
        zReq = 1'b0;
        @(negedge clk);
        zReq = 1'b1; zRw = 1'b0;
        ackCnt = 0; consec = 1'b0; prev = 1'b0; badData = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (zAck && prev) consec = 1'b1;
            if (zAck) begin
                ackCnt++;
                if (zData != 32'hCAFE_F00D) badData = 1'b1;
            end
            prev = zAck;
        end
        zReq = 1'b0;
        checkOutput("z0AckCount", ackCnt, 6);
        checkOutput("z0NoConsecutive", 32'(consec), 32'd0);
        checkOutput("z0LoadData", 32'(badData), 32'd0);
        checkOutput("z0InstIdle", {31'd0, zInstAck} | zInstData, 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
        checkOutput("z0Err", 32'(zErr), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
